// File: rtl/fetch_sequencer.sv
// fetch_sequencer: moves the instruction unit through request, wait, load and hold
// for each fetch, hands the instruction to decode and applies branch redirects.
module fetch_sequencer #(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             halt,
  input  logic             ir_ack,
  input  logic             br_req,
  input  logic [31:0]      br_target,
  output logic             PC_ld,
  output logic             PC_inc,
  output logic [31:0]      PC_in,
  output logic             IM_cs,
  output logic             IM_rd,
  output logic             IR_ld,
  output logic             ir_valid,
  output logic             busy,
  output logic [CNT_W-1:0] fetch_cnt
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, LOAD, HOLD, REDIR} state_t;
  state_t           state_q, state_d;
  logic [3:0]       wcnt_q, wcnt_d;
  logic             halt_pend_q, halt_pend_d;
  logic [31:0]      pc_in_q, pc_in_d;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      halt_pend_q <= 1'b0;
      pc_in_q     <= '0;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      halt_pend_q <= halt_pend_d;
      pc_in_q     <= pc_in_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    pc_in_d     = pc_in_q;
    fetch_cnt_d = fetch_cnt_q;
    case (state_q)
      IDLE:  state_d = go ? REQ : IDLE;
      REQ: begin
        wcnt_d  = 4'(MEM_LAT - 1);
        state_d = (MEM_LAT == 1) ? LOAD : WAIT;
      end
      WAIT: begin
        wcnt_d  = wcnt_q - 4'd1;
        state_d = (wcnt_q <= 4'd1) ? LOAD : WAIT;
      end
      LOAD: begin
        fetch_cnt_d = fetch_cnt_q + 1'b1;
        state_d     = HOLD;
      end
      HOLD:
        if (ir_ack) begin
          pc_in_d = br_req ? br_target : pc_in_q;
          state_d = br_req ? REDIR : (halt_pend_q ? IDLE : REQ);
        end
      REDIR: state_d = halt_pend_q ? IDLE : REQ;
      default: state_d = IDLE;
    endcase
    // halt sticks until the FSM lands in IDLE; in IDLE it only counts alongside go
    halt_pend_d = (state_d == IDLE) ? 1'b0 : (halt_pend_q | halt);
  end
  assign IM_cs     = (state_q == REQ) || (state_q == WAIT) || (state_q == LOAD);
  assign IM_rd     = IM_cs;
  assign IR_ld     = (state_q == LOAD);
  assign PC_inc    = (state_q == LOAD);
  assign PC_ld     = (state_q == REDIR);
  assign ir_valid  = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign PC_in     = pc_in_q;
  assign fetch_cnt = fetch_cnt_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed checks on a MEM_LAT=1 instance (a) and a MEM_LAT=3,
// 4-bit counter instance (b) driven by shared inputs.
module tb_fetch_sequencer;
  logic clk = 0, rst_n = 1, go = 0, halt = 0, ack = 0, br = 0;
  logic [31:0] tgt = '0;
  logic a_pc_ld, a_pc_inc, a_im_cs, a_im_rd, a_ir_ld, a_ir_valid, a_busy;
  logic b_pc_ld, b_pc_inc, b_im_cs, b_im_rd, b_ir_ld, b_ir_valid, b_busy;
  logic [31:0] a_pc_in, b_pc_in;
  logic [15:0] a_cnt;
  logic [3:0]  b_cnt;
  int checks = 0, fails = 0;
  always #5 clk = ~clk;
  fetch_sequencer #(.MEM_LAT(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(rst_n), .go(go), .halt(halt), .ir_ack(ack), .br_req(br), .br_target(tgt),
    .PC_ld(a_pc_ld), .PC_inc(a_pc_inc), .PC_in(a_pc_in), .IM_cs(a_im_cs), .IM_rd(a_im_rd),
    .IR_ld(a_ir_ld), .ir_valid(a_ir_valid), .busy(a_busy), .fetch_cnt(a_cnt));
  fetch_sequencer #(.MEM_LAT(3), .CNT_W(4)) dut_b (
    .clk(clk), .reset(rst_n), .go(go), .halt(halt), .ir_ack(ack), .br_req(br), .br_target(tgt),
    .PC_ld(b_pc_ld), .PC_inc(b_pc_inc), .PC_in(b_pc_in), .IM_cs(b_im_cs), .IM_rd(b_im_rd),
    .IR_ld(b_ir_ld), .ir_valid(b_ir_valid), .busy(b_busy), .fetch_cnt(b_cnt));
  task automatic step();
    @(negedge clk);
  endtask
  task automatic do_reset();
    step();
    rst_n = 0; go = 0; halt = 0; ack = 0; br = 0; tgt = '0;
    step();
    rst_n = 1;
  endtask
  task automatic test_reset();
    step();
    rst_n = 0;
    #1;
    checks++;
    if ({a_pc_ld, a_pc_inc, a_im_cs, a_im_rd, a_ir_ld, a_ir_valid, a_busy} !== 7'b0) begin
      fails++; $display("FAIL reset_a_strobes got %b want 0", {a_pc_ld, a_pc_inc, a_im_cs, a_im_rd, a_ir_ld, a_ir_valid, a_busy});
    end
    checks++;
    if (a_pc_in !== 32'h0 || a_cnt !== 16'h0 || b_cnt !== 4'h0) begin
      fails++; $display("FAIL reset_regs got pc_in=%h a_cnt=%h b_cnt=%h want 0", a_pc_in, a_cnt, b_cnt);
    end
    step();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (a_busy !== 1'b0 || b_busy !== 1'b0 || a_im_rd !== 1'b0) begin
        fails++; $display("FAIL reset_idle cycle %0d got busy=%b/%b im_rd=%b want 0", i, a_busy, b_busy, a_im_rd);
      end
    end
  endtask
  task automatic test_steady();
    do_reset();
    go = 1; ack = 1;
    for (int i = 0; i < 9; i++) begin
      step();
      go = 0;
      checks++;
      if ({a_ir_ld, a_pc_inc, a_im_rd, a_ir_valid} !== {i % 3 == 1, i % 3 == 1, i % 3 != 2, i % 3 == 2}) begin
        fails++; $display("FAIL steady cycle %0d got ir_ld/pc_inc/im_rd/ir_valid=%b want %b", i,
          {a_ir_ld, a_pc_inc, a_im_rd, a_ir_valid}, {i % 3 == 1, i % 3 == 1, i % 3 != 2, i % 3 == 2});
      end
    end
    checks++;
    if (a_cnt !== 16'd3) begin
      fails++; $display("FAIL steady_cnt got %0d want 3", a_cnt);
    end
  endtask
  task automatic test_wait_hold();
    do_reset();
    go = 1; ack = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      go = 0;
      checks++;
      if ({b_im_rd, b_ir_ld, b_ir_valid} !== {i < 4, i == 3, i >= 4}) begin
        fails++; $display("FAIL wait_hold cycle %0d got im_rd/ir_ld/ir_valid=%b want %b", i,
          {b_im_rd, b_ir_ld, b_ir_valid}, {i < 4, i == 3, i >= 4});
      end
    end
    ack = 1;
    step();
    ack = 0;
    checks++;
    if (b_im_rd !== 1'b1 || b_ir_valid !== 1'b0 || b_cnt !== 4'd1) begin
      fails++; $display("FAIL wait_hold_ack got im_rd=%b ir_valid=%b cnt=%0d want 1 0 1", b_im_rd, b_ir_valid, b_cnt);
    end
  endtask
  task automatic test_branch();
    do_reset();
    go = 1;
    step();
    go = 0;
    step();
    step();
    br = 1; tgt = 32'h0000_0040;
    step();
    checks++;
    if (a_ir_valid !== 1'b1 || a_pc_in !== 32'h0 || a_pc_ld !== 1'b0) begin
      fails++; $display("FAIL branch_no_ack got ir_valid=%b pc_in=%h pc_ld=%b want 1 0 0", a_ir_valid, a_pc_in, a_pc_ld);
    end
    ack = 1;
    step();
    ack = 0; br = 0; tgt = 32'hdead_beef;
    checks++;
    if ({a_pc_ld, a_pc_inc, a_im_rd} !== 3'b100 || a_pc_in !== 32'h40) begin
      fails++; $display("FAIL branch_redir got pc_ld/pc_inc/im_rd=%b pc_in=%h want 100 40", {a_pc_ld, a_pc_inc, a_im_rd}, a_pc_in);
    end
    step();
    checks++;
    if (a_im_rd !== 1'b1 || a_pc_ld !== 1'b0 || a_pc_in !== 32'h40) begin
      fails++; $display("FAIL branch_req got im_rd=%b pc_ld=%b pc_in=%h want 1 0 40", a_im_rd, a_pc_ld, a_pc_in);
    end
  endtask
  task automatic test_halt();
    do_reset();
    go = 1;
    step();
    go = 0;
    step();
    halt = 1;
    step();
    halt = 0;
    step();
    checks++;
    if (b_ir_ld !== 1'b1) begin
      fails++; $display("FAIL halt_load got ir_ld=%b want 1", b_ir_ld);
    end
    step();
    checks++;
    if (b_ir_valid !== 1'b1) begin
      fails++; $display("FAIL halt_hold got ir_valid=%b want 1", b_ir_valid);
    end
    ack = 1;
    step();
    ack = 0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (b_busy !== 1'b0 || b_im_rd !== 1'b0) begin
        fails++; $display("FAIL halt_idle cycle %0d got busy=%b im_rd=%b want 0 0", i, b_busy, b_im_rd);
      end
      step();
    end
    do_reset();
    go = 1; halt = 1; ack = 1;
    step();
    go = 0; halt = 0;
    step();
    step();
    step();
    checks++;
    if (a_busy !== 1'b0 || a_cnt !== 16'd1) begin
      fails++; $display("FAIL go_halt got busy=%b cnt=%0d want 0 1", a_busy, a_cnt);
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    go = 1; ack = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      go = 0;
    end
    checks++;
    if (a_ir_ld !== 1'b1 || a_cnt !== 16'd1) begin
      fails++; $display("FAIL mid_pre got ir_ld=%b cnt=%0d want 1 1", a_ir_ld, a_cnt);
    end
    #1 rst_n = 0;
    #1;
    checks++;
    if ({a_pc_ld, a_pc_inc, a_im_cs, a_im_rd, a_ir_ld, a_ir_valid, a_busy} !== 7'b0 || a_cnt !== 16'd0) begin
      fails++; $display("FAIL mid_reset got strobes=%b cnt=%0d want 0 0",
        {a_pc_ld, a_pc_inc, a_im_cs, a_im_rd, a_ir_ld, a_ir_valid, a_busy}, a_cnt);
    end
    ack = 0;
    step();
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (a_busy !== 1'b0 || a_im_rd !== 1'b0 || a_cnt !== 16'd0) begin
        fails++; $display("FAIL mid_after cycle %0d got busy=%b im_rd=%b cnt=%0d want 0 0 0", i, a_busy, a_im_rd, a_cnt);
      end
    end
  endtask
  task automatic test_wrap();
    do_reset();
    go = 1; ack = 1;
    for (int i = 0; i < 75; i++) begin
      step();
      go = 0;
      checks++;
      if (b_im_cs !== b_im_rd || (b_ir_valid & b_im_rd) || (b_pc_ld & b_pc_inc) || (b_ir_ld & !b_im_rd)) begin
        fails++; $display("FAIL invariant cycle %0d got cs=%b rd=%b ir_valid=%b pc_ld=%b pc_inc=%b ir_ld=%b",
          i, b_im_cs, b_im_rd, b_ir_valid, b_pc_ld, b_pc_inc, b_ir_ld);
      end
    end
    checks++;
    if (b_cnt !== 4'hF || b_ir_valid !== 1'b1) begin
      fails++; $display("FAIL wrap_max got cnt=%h ir_valid=%b want f 1", b_cnt, b_ir_valid);
    end
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (b_cnt !== 4'h0 || b_ir_valid !== 1'b1) begin
      fails++; $display("FAIL wrap_zero got cnt=%h ir_valid=%b want 0 1", b_cnt, b_ir_valid);
    end
    ack = 0;
  endtask
  initial begin
    test_reset();
    test_steady();
    test_wait_hold();
    test_branch();
    test_halt();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
